// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared widths, frame-tracking state encoding and the framing rule for packet streams.
// A word carrying any non-zero ctrl bit marks a packet boundary (start or end).
package pkt_rr_arbiter_pkg;

    localparam int unsigned PKT_DATA_W = 64;
    localparam int unsigned PKT_CTRL_W = 8;
    localparam int unsigned PKT_CNT_W  = 16;
    localparam int unsigned CTRL_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } frame_state_e;

    // Callers zero-extend their ctrl field; zero-extension does not change the OR.
    function automatic logic is_ctrl_word(input logic [CTRL_MAX_W-1:0] ctrl);
        return |ctrl;
    endfunction

endpackage

// File: rtl/pkt_frame_tracker.sv
// Follows one stream's accepted words through header and body, flags the packet end
// and latches a sticky error when a header-phase word arrives with ctrl==0 before any start word.
module pkt_frame_tracker
    import pkt_rr_arbiter_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = PKT_CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    output frame_state_e          o_state,
    output logic                  o_pkt_end_c,
    output logic                  o_frame_err
);

    logic         w_is_ctrl;
    frame_state_e r_state;
    logic         r_start_seen;
    logic         r_frame_err;

    assign w_is_ctrl   = is_ctrl_word(CTRL_MAX_W'(i_ctrl));
    assign o_pkt_end_c = (r_state == ST_BODY) & i_valid & w_is_ctrl;
    assign o_state     = r_state;
    assign o_frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_seen <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_HDR;
                        r_start_seen <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (i_valid) begin
                        if (w_is_ctrl) begin
                            r_start_seen <= 1'b1;
                        end else if (r_start_seen) begin
                            r_state <= ST_BODY;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                ST_BODY: begin
                    if (i_valid && w_is_ctrl) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Two-input packet-granular round-robin arbiter: the grant is held for a whole packet,
// the merged stream is registered, and completed packets are counted per input.
module pkt_rr_arbiter
    import pkt_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PKT_DATA_W,
    parameter int unsigned CTRL_WIDTH = PKT_CTRL_W,
    parameter int unsigned CNT_WIDTH  = PKT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in0_req,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_wr,
    output logic                  in0_rdy,
    input  logic                  in1_req,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_wr,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [1:0]            grant,
    output logic                  frame_err
);

    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_acc;
    logic                  w_start;
    logic                  w_pkt_end;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [CTRL_WIDTH-1:0] w_sel_ctrl;
    frame_state_e          w_state;

    logic [1:0]            r_grant;
    logic                  r_prio;
    logic [CNT_WIDTH-1:0]  r_cnt0;
    logic [CNT_WIDTH-1:0]  r_cnt1;
    logic                  r_out_wr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;

    // Only the owner may write, and only while downstream can take the word.
    assign in0_rdy    = r_grant[0] & out_rdy;
    assign in1_rdy    = r_grant[1] & out_rdy;
    assign w_acc0     = in0_wr & in0_rdy;
    assign w_acc1     = in1_wr & in1_rdy;
    assign w_acc      = w_acc0 | w_acc1;
    assign w_sel_data = r_grant[1] ? in1_data : in0_data;
    assign w_sel_ctrl = r_grant[1] ? in1_ctrl : in0_ctrl;
    assign w_start    = (w_state == ST_IDLE) & (in0_req | in1_req);

    pkt_frame_tracker #(
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_frame (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_valid     (w_acc),
        .i_ctrl      (w_sel_ctrl),
        .o_state     (w_state),
        .o_pkt_end_c (w_pkt_end),
        .o_frame_err (frame_err)
    );

    // Arbitration happens only between packets; the finishing owner hands priority over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= 2'b00;
            r_prio  <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else if (w_start) begin
            if (in0_req && (!in1_req || !r_prio)) begin
                r_grant <= 2'b01;
            end else begin
                r_grant <= 2'b10;
            end
        end else if (w_pkt_end) begin
            r_grant <= 2'b00;
            r_prio  <= r_grant[0];
            if (r_grant[0]) begin
                r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end else begin
                r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
        end else begin
            r_out_wr <= w_acc;
            if (w_acc) begin
                r_out_data <= w_sel_data;
                r_out_ctrl <= w_sel_ctrl;
            end
        end
    end

    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign out_ctrl = r_out_ctrl;
    assign pkt_cnt0 = r_cnt0;
    assign pkt_cnt1 = r_cnt1;
    assign grant    = r_grant;

endmodule
